// File: rtl/ram.sv
// Wishbone classic RAM responder with programmable wait states and ERR on out-of-window accesses.
// Define RAM_ALIGN_CHECK_EN to also reject misaligned addresses and unsupported byte-select patterns.
module ram #(
    parameter int                   DAT_WIDTH   = 32,
    parameter int                   ADR_WIDTH   = 32,
    parameter int                   SEL_WIDTH   = DAT_WIDTH / 8,
    parameter int                   WORDS       = 256,
    parameter logic [ADR_WIDTH-1:0] BASE_ADDR   = 32'h0000_1000,
    parameter int                   WAIT_STATES = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ram_stb_i,
    input  logic                 ram_cyc_i,
    input  logic                 ram_we_i,
    input  logic [SEL_WIDTH-1:0] ram_sel_i,
    input  logic [ADR_WIDTH-1:0] ram_adr_i,
    input  logic [DAT_WIDTH-1:0] ram_dat_i,
    output logic [DAT_WIDTH-1:0] ram_dat_o,
    output logic                 ram_ack_o,
    output logic                 ram_err_o
);
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [ADR_WIDTH:0] SPAN = (ADR_WIDTH + 1)'(WORDS) << 2;
    localparam logic [3:0] WS_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]           state_reg;
    logic [3:0]           cnt_reg;
    logic [IDX_W-1:0]     cap_idx_reg;
    logic                 cap_we_reg;
    logic [SEL_WIDTH-1:0] cap_sel_reg;
    logic [DAT_WIDTH-1:0] cap_dat_reg;
    logic                 cap_ok_reg;

    logic [ADR_WIDTH-1:0] off;
    logic                 req;
    logic                 req_ok;
    logic [IDX_W-1:0]     req_idx;
    logic [IDX_W-1:0]     rd_idx;
    logic                 wr_en;
    logic                 resp;
    logic [DAT_WIDTH-1:0] rd_word;
    logic [DAT_WIDTH-1:0] sel_mask;

    assign off     = ram_adr_i - BASE_ADDR;
    assign req     = ram_cyc_i & ram_stb_i;
    assign req_idx = off[IDX_W+1:2];

`ifdef RAM_ALIGN_CHECK_EN
    logic sel_legal;
    always_comb begin
        sel_legal = (ram_sel_i == SEL_WIDTH'(4'b0001)) || (ram_sel_i == SEL_WIDTH'(4'b0010)) ||
                    (ram_sel_i == SEL_WIDTH'(4'b0100)) || (ram_sel_i == SEL_WIDTH'(4'b1000)) ||
                    (ram_sel_i == SEL_WIDTH'(4'b0011)) || (ram_sel_i == SEL_WIDTH'(4'b1100)) ||
                    (ram_sel_i == SEL_WIDTH'(4'b1111));
    end
    assign req_ok = (ram_adr_i >= BASE_ADDR) && ({1'b0, off} < SPAN) &&
                    (ram_adr_i[1:0] == 2'b00) && sel_legal;
`else
    assign req_ok = (ram_adr_i >= BASE_ADDR) && ({1'b0, off} < SPAN);
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            cap_idx_reg <= '0;
            cap_we_reg  <= 1'b0;
            cap_sel_reg <= '0;
            cap_dat_reg <= '0;
            cap_ok_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (req) begin
                        cap_idx_reg <= req_idx;
                        cap_we_reg  <= ram_we_i;
                        cap_sel_reg <= ram_sel_i;
                        cap_dat_reg <= ram_dat_i;
                        cap_ok_reg  <= req_ok;
                        cnt_reg     <= WS_INIT;
                        state_reg   <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Master withdrawing cyc or stb abandons the access silently.
                    if (!req) begin
                        state_reg <= S_IDLE;
                    end else if (cnt_reg == 4'd0) begin
                        state_reg <= S_RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                S_RESP:  state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // The read port is addressed one edge ahead so data is ready during the response cycle.
    assign rd_idx = (state_reg == S_IDLE) ? req_idx : cap_idx_reg;
    assign resp   = (state_reg == S_RESP);
    assign wr_en  = resp && cap_we_reg && cap_ok_reg;

    for (genvar gi = 0; gi < SEL_WIDTH; gi++) begin : g_lane
        logic [7:0] mem [WORDS];
        logic [7:0] rd_byte_reg;

        always_ff @(posedge clk_i) begin
            if (wr_en && cap_sel_reg[gi]) begin
                mem[cap_idx_reg] <= cap_dat_reg[gi*8 +: 8];
            end
            rd_byte_reg <= mem[rd_idx];
        end

        assign rd_word[gi*8 +: 8]  = rd_byte_reg;
        assign sel_mask[gi*8 +: 8] = {8{cap_sel_reg[gi]}};
    end

    assign ram_ack_o = resp && cap_ok_reg;
    assign ram_err_o = resp && !cap_ok_reg;
    // Zero outside read acks so the intercon can OR slave data buses together.
    assign ram_dat_o = (ram_ack_o && !cap_we_reg) ? (rd_word & sel_mask) : '0;

endmodule

// File: tb/tb_ram.sv
// Self-checking bench for ram: three instances (1, 0 and 3 wait states) against a word-array reference model.
module tb_ram;
    localparam int NI = 3;
`ifdef RAM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n [NI];
    logic        stb   [NI];
    logic        cyc   [NI];
    logic        we    [NI];
    logic [3:0]  sel   [NI];
    logic [31:0] adr   [NI];
    logic [31:0] dati  [NI];
    logic [31:0] dato  [NI];
    logic        ack   [NI];
    logic        err   [NI];

    logic [31:0] model [NI][256];
    int checks = 0;
    int errors = 0;
    bit run_mon = 1'b0;

    always #5 clk = ~clk;

    ram #(.WAIT_STATES(1)) u_ram0 (
        .clk_i(clk), .rst_i(rst_n[0]), .ram_stb_i(stb[0]), .ram_cyc_i(cyc[0]), .ram_we_i(we[0]),
        .ram_sel_i(sel[0]), .ram_adr_i(adr[0]), .ram_dat_i(dati[0]), .ram_dat_o(dato[0]),
        .ram_ack_o(ack[0]), .ram_err_o(err[0]));
    ram #(.WAIT_STATES(0)) u_ram1 (
        .clk_i(clk), .rst_i(rst_n[1]), .ram_stb_i(stb[1]), .ram_cyc_i(cyc[1]), .ram_we_i(we[1]),
        .ram_sel_i(sel[1]), .ram_adr_i(adr[1]), .ram_dat_i(dati[1]), .ram_dat_o(dato[1]),
        .ram_ack_o(ack[1]), .ram_err_o(err[1]));
    ram #(.WAIT_STATES(3)) u_ram2 (
        .clk_i(clk), .rst_i(rst_n[2]), .ram_stb_i(stb[2]), .ram_cyc_i(cyc[2]), .ram_we_i(we[2]),
        .ram_sel_i(sel[2]), .ram_adr_i(adr[2]), .ram_dat_i(dati[2]), .ram_dat_o(dato[2]),
        .ram_ack_o(ack[2]), .ram_err_o(err[2]));

    function automatic int ws_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    function automatic logic exp_ok(input logic [31:0] a, input logic [3:0] s);
        logic r;
        r = (a >= 32'h1000) && (a < 32'h1000 + 4 * 256);
        if (ALIGN_CHK && ((a % 4) != 0 ||
            !(s inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111})))
            r = 1'b0;
        return r;
    endfunction

    function automatic logic [31:0] mask_of(input logic [3:0] s);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[b*8 +: 8] = s[b] ? 8'hFF : 8'h00;
        return m;
    endfunction

    // Bus outputs must obey the termination rules on every cycle.
    always @(negedge clk) begin
        if (run_mon) begin
            for (int k = 0; k < NI; k++) begin
                checks++;
                assert (!(ack[k] && err[k]) && (ack[k] || dato[k] == 32'h0)) else begin
                    errors++;
                    $error("FAIL bus_rules u%0d: ack=%0b err=%0b dat=%h required no ack+err and dat=0 without ack",
                           k, ack[k], err[k], dato[k]);
                end
            end
        end
    end

    task automatic xfer(input int k, input logic w, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] d, input bit verbose, input string tag);
        logic        ok;
        logic [7:0]  idx;
        logic [31:0] exp_d;
        logic        o_ack, o_err;
        logic [31:0] o_dat;
        int          lat;
        ok    = exp_ok(a, s);
        idx   = 8'((a - 32'h1000) >> 2);
        exp_d = (ok && !w) ? (model[k][idx] & mask_of(s)) : 32'h0;
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; sel[k] = s; adr[k] = a; dati[k] = d;
        @(posedge clk); #1;
        lat = 1;
        while (!(ack[k] || err[k]) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        o_ack = ack[k]; o_err = err[k]; o_dat = dato[k];
        cyc[k] = 1'b0; stb[k] = 1'b0;
        @(posedge clk); #1;
        checks++;
        assert (lat === ws_of(k) + 1) else begin
            errors++; $error("FAIL %s latency: got %0d required %0d", tag, lat, ws_of(k) + 1);
        end
        checks++;
        assert (o_ack === ok && o_err === !ok) else begin
            errors++; $error("FAIL %s term: ack=%0b err=%0b required ack=%0b err=%0b", tag, o_ack, o_err, ok, !ok);
        end
        if (!w || !ok) begin
            checks++;
            assert (o_dat === exp_d) else begin
                errors++; $error("FAIL %s data: got %h required %h", tag, o_dat, exp_d);
            end
        end
        if (w && ok) begin
            for (int b = 0; b < 4; b++) if (s[b]) model[k][idx][b*8 +: 8] = d[b*8 +: 8];
        end
        if (verbose)
            $display("xfer %s u%0d we=%0b sel=%b adr=%h wdat=%h -> ack=%0b err=%0b rdat=%h lat=%0d",
                     tag, k, w, s, a, d, o_ack, o_err, o_dat, lat);
    endtask

    initial begin
        logic [31:0] a, d;
        logic [3:0]  s;
        logic        w;
        int          pick;
        logic        exp_ack [4];

        for (int k = 0; k < NI; k++) begin
            rst_n[k] = 1'b0; stb[k] = 1'b0; cyc[k] = 1'b0; we[k] = 1'b0;
            sel[k] = 4'h0; adr[k] = 32'h0; dati[k] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            checks++;
            assert (ack[k] === 1'b0 && err[k] === 1'b0 && dato[k] === 32'h0) else begin
                errors++; $error("FAIL reset_u%0d: ack=%0b err=%0b dat=%h required 0/0/0", k, ack[k], err[k], dato[k]);
            end
        end
        @(negedge clk);
        for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;
        @(posedge clk); #1;
        run_mon = 1'b1;

        // Give every word a known value before any partial writes or reads.
        for (int i = 0; i < 256; i++) xfer(0, 1'b1, 4'hF, 32'h1000 + 4 * i, $urandom, 1'b0, "fill0");
        for (int i = 0; i < 8; i++) begin
            xfer(1, 1'b1, 4'hF, 32'h1000 + 4 * i, $urandom, 1'b0, "fill1");
            xfer(2, 1'b1, 4'hF, 32'h1000 + 4 * i, $urandom, 1'b0, "fill2");
        end

        xfer(0, 1'b1, 4'hF, 32'h1004, 32'hDEADBEEF, 1'b1, "wr_1004");
        xfer(0, 1'b0, 4'hF, 32'h1004, 32'h0, 1'b1, "rd_1004");
        xfer(0, 1'b1, 4'hF, 32'h1008, 32'h11223344, 1'b1, "pre_1008");
        xfer(0, 1'b1, 4'b0101, 32'h1008, 32'hAABBCCDD, 1'b1, "lanes_wr");
        xfer(0, 1'b0, 4'hF, 32'h1008, 32'h0, 1'b1, "lanes_rd_all");
        xfer(0, 1'b0, 4'b0011, 32'h1008, 32'h0, 1'b1, "lanes_rd_lo");
        xfer(0, 1'b0, 4'hF, 32'h1400, 32'h0, 1'b1, "rd_above");
        xfer(0, 1'b0, 4'hF, 32'h0FFC, 32'h0, 1'b1, "rd_below");
        xfer(0, 1'b1, 4'hF, 32'h1400, 32'h5A5A5A5A, 1'b1, "wr_above");
        xfer(0, 1'b0, 4'hF, 32'h13FC, 32'h0, 1'b1, "rd_last");
        xfer(0, 1'b0, 4'hF, 32'h1002, 32'h0, 1'b1, "rd_unaligned");
        xfer(0, 1'b1, 4'b0110, 32'h1000, 32'hCAFEF00D, 1'b1, "wr_sel0110");
        xfer(0, 1'b0, 4'hF, 32'h1000, 32'h0, 1'b1, "rd_after0110");
        xfer(0, 1'b1, 4'h0, 32'h100C, 32'hFFFFFFFF, 1'b1, "wr_sel0");
        xfer(0, 1'b0, 4'hF, 32'h100C, 32'h0, 1'b1, "rd_after_sel0");

        // Abort by dropping cyc one cycle into the wait phase.
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; sel[2] = 4'hF; adr[2] = 32'h1010; dati[2] = ~model[2][4];
        @(posedge clk); #1;
        cyc[2] = 1'b0; stb[2] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            assert (ack[2] === 1'b0 && err[2] === 1'b0) else begin
                errors++; $error("FAIL abort_cyc: ack=%0b err=%0b required 0/0", ack[2], err[2]);
            end
        end
        $display("xfer abort_cyc u2 adr=00001010 -> no response");
        xfer(2, 1'b0, 4'hF, 32'h1010, 32'h0, 1'b1, "rd_after_abort");

        // Abort by dropping stb alone while cyc stays high.
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; sel[2] = 4'hF; adr[2] = 32'h1010; dati[2] = ~model[2][4];
        @(posedge clk); #1;
        stb[2] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            assert (ack[2] === 1'b0 && err[2] === 1'b0) else begin
                errors++; $error("FAIL abort_stb: ack=%0b err=%0b required 0/0", ack[2], err[2]);
            end
        end
        cyc[2] = 1'b0;
        $display("xfer abort_stb u2 adr=00001010 -> no response");
        xfer(2, 1'b0, 4'hF, 32'h1010, 32'h0, 1'b1, "rd_after_abort_stb");

        // Reset asserted during the response cycle of a write.
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; sel[2] = 4'hF; adr[2] = 32'h1010; dati[2] = ~model[2][4];
        pick = 0;
        @(posedge clk); #1;
        while (!ack[2] && pick < 40) begin
            @(posedge clk); #1;
            pick++;
        end
        rst_n[2] = 1'b0;
        #1;
        checks++;
        assert (ack[2] === 1'b0 && err[2] === 1'b0 && dato[2] === 32'h0) else begin
            errors++; $error("FAIL reset_mid: ack=%0b err=%0b dat=%h required 0/0/0", ack[2], err[2], dato[2]);
        end
        cyc[2] = 1'b0; stb[2] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n[2] = 1'b1;
        @(posedge clk); #1;
        $display("xfer reset_mid u2 adr=00001010 -> reset during response");
        xfer(2, 1'b0, 4'hF, 32'h1010, 32'h0, 1'b1, "rd_after_reset");

        // Held request with zero wait states: acks must alternate with idle cycles.
        exp_ack = '{1'b1, 1'b0, 1'b1, 1'b0};
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; sel[1] = 4'hF; adr[1] = 32'h1000;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            assert (ack[1] === exp_ack[i]) else begin
                errors++; $error("FAIL b2b_ack%0d: ack=%0b required %0b", i, ack[1], exp_ack[i]);
            end
            if (exp_ack[i]) begin
                d = (i == 0) ? model[1][0] : model[1][1];
                checks++;
                assert (dato[1] === d) else begin
                    errors++; $error("FAIL b2b_dat%0d: got %h required %h", i, dato[1], d);
                end
            end
            $display("xfer b2b u1 cycle=%0d adr=%h -> ack=%0b rdat=%h", i, adr[1], ack[1], dato[1]);
            if (i == 0) adr[1] = 32'h1004;
            if (i == 2) begin
                cyc[1] = 1'b0; stb[1] = 1'b0;
            end
        end

        // Stb without cyc must be ignored.
        stb[1] = 1'b1; adr[1] = 32'h1000;
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            assert (ack[1] === 1'b0 && err[1] === 1'b0) else begin
                errors++; $error("FAIL stb_only: ack=%0b err=%0b required 0/0", ack[1], err[1]);
            end
        end
        stb[1] = 1'b0;
        @(posedge clk); #1;

        for (int n = 0; n < 150; n++) begin
            pick = $urandom_range(0, 9);
            if (pick == 0)      a = 32'h1400 + 32'($urandom_range(0, 255));
            else if (pick == 1) a = 32'h0F00 + 32'($urandom_range(0, 255));
            else                a = 32'h1000 + 32'($urandom_range(0, 1023));
            if (pick > 6) a = a & 32'hFFFF_FFFC;
            s = 4'($urandom_range(0, 15));
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            xfer(0, w, s, a, d, 1'b1, "rand");
        end

        run_mon = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram.md
Name: ram

Overview:
- Wishbone classic responder: single-port synchronous RAM on the SoC slave bus, alongside the existing rom and uart slaves.
- Serves CPU word reads and byte-lane writes through the intercon.
- Adds a configurable wait-state delay before each response.
- Signals ERR for out-of-window accesses.

Parameters:
- DAT_WIDTH, 32, data bus width (multiple of 8).
- ADR_WIDTH, 32, address bus width.
- SEL_WIDTH, 4, byte-lane selects (DAT_WIDTH/8).
- WORDS, 256, RAM depth in words (power of two).
- BASE_ADDR, 32'h0000_1000, byte address of word 0.
- WAIT_STATES, 1, idle cycles between request capture and response (0..15).

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- ram_stb_i  in  1  strobe from intercon.
- ram_cyc_i  in  1  bus cycle valid.
- ram_we_i  in  1  1=write, 0=read.
- ram_sel_i  in  SEL_WIDTH  byte-lane enables.
- ram_adr_i  in  ADR_WIDTH  byte address.
- ram_dat_i  in  DAT_WIDTH  write data.
- ram_dat_o  out  DAT_WIDTH  read data.
- ram_ack_o  out  1  normal termination.
- ram_err_o  out  1  error termination.

Behaviour:
- Reset (rst_i=0, async): state=IDLE, ram_ack_o=0, ram_err_o=0, ram_dat_o=0, wait counter=0. Memory contents are not cleared.
- Decode: off = adr - BASE_ADDR, index = off[ADR_WIDTH-1:2]. In range iff adr >= BASE_ADDR and index < WORDS.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On rising edge with cyc&stb, capture adr/we/sel/dat and the decode result.
  - Go to WAIT with counter=WAIT_STATES-1, or directly to RESP if WAIT_STATES=0.
- WAIT: counter decrements each cycle. At 0, go to RESP.
- RESP (one cycle only):
  - ack=1 if the captured access is in range, else err=1. Never both.
  - Write, in range: selected byte lanes of mem[index] updated at the end of this cycle. Unselected lanes unchanged. sel=0 acks with no change.
  - Read, in range: ram_dat_o = mem[index] with unselected lanes forced to 0.
  - Error: ram_dat_o=0, no memory change.
  - Next state: IDLE.
- Latency: ack/err asserted exactly WAIT_STATES+1 cycles after the capturing edge (WAIT_STATES=0 gives ack in the cycle after capture).
- ram_dat_o is 0 whenever ack=0, so the intercon may OR-combine slave data.
- Back-to-back: a request still present in the cycle after RESP is captured as a new access. Minimum spacing between responses is WAIT_STATES+2 cycles.
- Abort: cyc=0 while in WAIT returns to IDLE next edge. No response, no write. stb=0 with cyc=1 in WAIT also aborts.
- stb without cyc is ignored.
- Read-after-write to the same word returns the new data.
- Reset asserted mid-operation: outputs drop immediately and the pending write is discarded.

Optional Feature:
- Macro: RAM_ALIGN_CHECK_EN.
- Defined: an access with adr[1:0]!=0, or with a sel pattern other than 0001/0010/0100/1000/0011/1100/1111, terminates with err and no memory change.
- Undefined: adr[1:0] ignored (word-aligned access), any sel pattern accepted.

Test Plan:
- WAIT_STATES=1: write 0xDEADBEEF to 0x1004 sel=1111, then read 0x1004 sel=1111 -> each ack 2 cycles after capture, read ram_dat_o=0xDEADBEEF, err=0.
- Byte lanes: preload 0x11223344 at 0x1008, write 0xAABBCCDD sel=0101, read sel=1111 -> 0x11BB33DD. Read sel=0011 -> 0x000033DD.
- Range: read 0x1400 and 0x0FFC -> err=1, ack=0, ram_dat_o=0. Write 0x1400 then read 0x13FC -> 0x13FC contents unchanged.
- Abort/reset: start write to 0x1010 with WAIT_STATES=3, drop cyc after 1 cycle -> no ack, word unchanged. Repeat with rst_i low mid-WAIT -> outputs 0 immediately, word unchanged.
- Back-to-back with WAIT_STATES=0: hold stb/cyc for reads of 0x1000 then 0x1004 -> ack pulses on alternate cycles with correct data, never two consecutive ack cycles.
- RAM_ALIGN_CHECK_EN defined: read 0x1002 -> err. Write sel=0110 -> err, memory unchanged. Undefined: read 0x1002 returns word 0x1000 with ack.
